// File: rtl/as2650_gpio_port.sv
// Byte-wide GPIO port for the AS2650 I/O bus: output/direction registers, pad input
// synchroniser, rising-edge detection and a registered level interrupt.
module as2650_gpio_port #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             wb_clk_i,
   input  logic             rst_n,
   input  logic [1:0]       bus_addr,
   input  logic [7:0]       bus_wdata,
   input  logic             bus_we,
   input  logic             bus_re,
   output logic [7:0]       bus_rdata,
   input  logic [WIDTH-1:0] pin_in,
   output logic [WIDTH-1:0] pin_out,
   output logic [WIDTH-1:0] pin_oeb,
   output logic             irq
);

   localparam logic [1:0] ADDR_DATA  = 2'd0;
   localparam logic [1:0] ADDR_DIR   = 2'd1;
   localparam logic [1:0] ADDR_IE    = 2'd2;
   localparam logic [1:0] ADDR_IFLAG = 2'd3;

   logic [WIDTH-1:0] out_reg;
   logic [WIDTH-1:0] dir_reg;
   logic [WIDTH-1:0] ie_reg;
   logic [WIDTH-1:0] iflag;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] pin_sync;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] flag_set;
   logic [WIDTH-1:0] flag_clr;
   logic [WIDTH-1:0] wr_data;
   logic [7:0]       rd_mux;

   // Register bits above WIDTH always read as zero.
   function automatic logic [7:0] zext(input logic [WIDTH-1:0] v);
      logic [7:0] r;
      r = '0;
      r[WIDTH-1:0] = v;
      return r;
   endfunction

   assign pin_sync = sync_q[SYNC_STAGES-1];
   assign wr_data  = bus_wdata[WIDTH-1:0];
   assign pin_out  = out_reg;
   assign pin_oeb  = ~dir_reg;

   // Pad input synchroniser followed by the edge-history flop
   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= pin_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= pin_sync;
      end
   end

   always_comb begin
      edge_det = pin_sync & ~prev_q;
      flag_set = edge_det & ie_reg;
      flag_clr = '0;
      if (bus_we && bus_addr == ADDR_IFLAG) flag_clr = wr_data;
   end

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         out_reg <= '0;
         dir_reg <= '0;
         ie_reg  <= '0;
      end else if (bus_we) begin
         case (bus_addr)
            ADDR_DATA: out_reg <= wr_data;
            ADDR_DIR:  dir_reg <= wr_data;
            ADDR_IE:   ie_reg  <= wr_data;
            default:   ;
         endcase
      end
   end

   // A set in the same cycle as its W1C wins, so no edge is ever lost.
   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         iflag <= '0;
         irq   <= 1'b0;
      end else begin
         iflag <= (iflag & ~flag_clr) | flag_set;
         irq   <= |iflag;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (bus_addr)
         ADDR_DATA:  rd_mux = zext(pin_sync);
         ADDR_DIR:   rd_mux = zext(dir_reg);
         ADDR_IE:    rd_mux = zext(ie_reg);
         ADDR_IFLAG: rd_mux = zext(iflag);
         default:    rd_mux = '0;
      endcase
   end

   // Read data holds between strobes and shows pre-write values on a combined strobe.
   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         bus_rdata <= '0;
      end else if (bus_re) begin
         bus_rdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_as2650_gpio_port.sv
// Self-checking bench for as2650_gpio_port: directed scenarios plus randomized traffic
// checked against a history-based reference model.
module tb_as2650_gpio_port;

   localparam int SYNC = 2;

   logic       clk;
   logic       rst_n;
   logic [1:0] bus_addr;
   logic [7:0] bus_wdata;
   logic       bus_we;
   logic       bus_re;
   logic [7:0] bus_rdata;
   logic [7:0] pin_in;
   logic [7:0] pin_out;
   logic [7:0] pin_oeb;
   logic       irq;

   int checks = 0;
   int errors = 0;

   as2650_gpio_port #(.WIDTH(8), .SYNC_STAGES(SYNC)) dut (
      .wb_clk_i  (clk),
      .rst_n     (rst_n),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_we    (bus_we),
      .bus_re    (bus_re),
      .bus_rdata (bus_rdata),
      .pin_in    (pin_in),
      .pin_out   (pin_out),
      .pin_oeb   (pin_oeb),
      .irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: registers plus the full history of pin samples since reset.
   logic [7:0] m_out, m_dir, m_ie, m_flag, m_rdata;
   logic       m_irq;
   logic [7:0] hist [$];

   function automatic logic [7:0] samp(int idx);
      if (idx >= 0 && idx < hist.size()) return hist[idx];
      return 8'h00;
   endfunction

   task automatic model_reset();
      m_out = 0; m_dir = 0; m_ie = 0; m_flag = 0; m_rdata = 0; m_irq = 0;
      hist.delete();
   endtask

   // Applies the effect of the next rising edge given the currently driven inputs.
   task automatic model_step();
      int n;
      logic [7:0] synced, prev, rising, clr;
      n      = hist.size();
      synced = samp(n - SYNC);
      prev   = samp(n - SYNC - 1);
      rising = synced & ~prev;
      if (bus_re) begin
         case (bus_addr)
            2'd0: m_rdata = synced;
            2'd1: m_rdata = m_dir;
            2'd2: m_rdata = m_ie;
            default: m_rdata = m_flag;
         endcase
      end
      m_irq  = (m_flag != 0);
      clr    = (bus_we && bus_addr == 2'd3) ? bus_wdata : 8'h00;
      m_flag = (m_flag & ~clr) | (rising & m_ie);
      if (bus_we) begin
         case (bus_addr)
            2'd0: m_out = bus_wdata;
            2'd1: m_dir = bus_wdata;
            2'd2: m_ie  = bus_wdata;
            default: ;
         endcase
      end
      hist.push_back(pin_in);
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      bus_we = 1'b1; bus_addr = a; bus_wdata = d;
      @(negedge clk);
      bus_we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] d);
      bus_re = 1'b1; bus_addr = a;
      @(negedge clk);
      bus_re = 1'b0;
      d = bus_rdata;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [7:0] d;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pin_in = 8'($urandom);
         @(negedge clk);
      end
      checks++; if (pin_out !== 8'h00) begin errors++; $display("FAIL reset_pin_out got %h want 00", pin_out); end
      checks++; if (pin_oeb !== 8'hFF) begin errors++; $display("FAIL reset_pin_oeb got %h want ff", pin_oeb); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
      checks++; if (bus_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", bus_rdata); end
      rst_n = 1'b1;
      @(negedge clk);
      rd(2'd3, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_iflag got %h want 00", d); end
   endtask

   task automatic test_output_path();
      logic [7:0] d;
      wr(2'd1, 8'h0F);
      checks++; if (pin_oeb !== 8'hF0) begin errors++; $display("FAIL out_oeb got %h want f0", pin_oeb); end
      wr(2'd0, 8'hA5);
      checks++; if (pin_out !== 8'hA5) begin errors++; $display("FAIL out_data got %h want a5", pin_out); end
      pin_in = 8'h3C;
      wait_cycles(3);
      rd(2'd0, d);
      checks++; if (d !== 8'h3C) begin errors++; $display("FAIL out_readback got %h want 3c", d); end
      wait_cycles(2);
      checks++; if (bus_rdata !== 8'h3C) begin errors++; $display("FAIL out_rdata_hold got %h want 3c", bus_rdata); end
   endtask

   task automatic test_edge_irq();
      logic [7:0] d;
      wr(2'd2, 8'h01);
      pin_in[0] = 1'b1;
      wait_cycles(3);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_irq_early got %b want 0", irq); end
      @(negedge clk);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL edge_irq_rise got %b want 1", irq); end
      rd(2'd3, d);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL edge_iflag got %h want 01", d); end
      wr(2'd3, 8'h01);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL edge_irq_clear_edge got %b want 1", irq); end
      @(negedge clk);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_irq_cleared got %b want 0", irq); end
   endtask

   task automatic test_disabled_edge();
      logic [7:0] d;
      wr(2'd2, 8'h00);
      pin_in[1] = 1'b1;
      wait_cycles(3);
      pin_in[1] = 1'b0;
      wait_cycles(4);
      wr(2'd2, 8'h02);
      wait_cycles(4);
      rd(2'd3, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL disabled_iflag got %h want 00", d); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL disabled_irq got %b want 0", irq); end
   endtask

   task automatic test_collision();
      logic [7:0] d;
      wr(2'd2, 8'hFF);
      pin_in[2] = 1'b0;
      wait_cycles(4);
      wr(2'd3, 8'hFF);
      pin_in[2] = 1'b1;
      wait_cycles(4);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL coll_setup_irq got %b want 1", irq); end
      pin_in[2] = 1'b0;
      wait_cycles(4);
      pin_in[2] = 1'b1;
      wait_cycles(2);
      wr(2'd3, 8'h04);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL coll_irq_a got %b want 1", irq); end
      @(negedge clk);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL coll_irq_b got %b want 1", irq); end
      rd(2'd3, d);
      checks++; if (d !== 8'h04) begin errors++; $display("FAIL coll_iflag got %h want 04", d); end
      wr(2'd3, 8'h04);
      @(negedge clk);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL coll_final_clear got %b want 0", irq); end
   endtask

   task automatic test_rw_and_async_reset();
      logic [7:0] d;
      wr(2'd1, 8'h0F);
      bus_we = 1'b1; bus_re = 1'b1; bus_addr = 2'd1; bus_wdata = 8'h55;
      @(negedge clk);
      bus_we = 1'b0; bus_re = 1'b0;
      checks++; if (bus_rdata !== 8'h0F) begin errors++; $display("FAIL rw_pre_value got %h want 0f", bus_rdata); end
      rd(2'd1, d);
      checks++; if (d !== 8'h55) begin errors++; $display("FAIL rw_dir_after got %h want 55", d); end
      checks++; if (pin_oeb !== 8'hAA) begin errors++; $display("FAIL rw_oeb got %h want aa", pin_oeb); end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (pin_oeb !== 8'hFF) begin errors++; $display("FAIL async_oeb got %h want ff", pin_oeb); end
      checks++; if (pin_out !== 8'h00) begin errors++; $display("FAIL async_out got %h want 00", pin_out); end
      checks++; if (bus_rdata !== 8'h00) begin errors++; $display("FAIL async_rdata got %h want 00", bus_rdata); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_random();
      rst_n = 1'b0;
      pin_in = 8'($urandom);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 600; i++) begin
         bus_we    = ($urandom % 3) == 0;
         bus_re    = ($urandom % 2) == 0;
         bus_addr  = 2'($urandom);
         bus_wdata = 8'($urandom);
         if (($urandom % 4) == 0) pin_in = 8'($urandom);
         model_step();
         @(negedge clk);
         checks++; if (pin_out !== m_out) begin errors++; $display("FAIL rand_pin_out cyc %0d got %h want %h", i, pin_out, m_out); end
         checks++; if (pin_oeb !== ~m_dir) begin errors++; $display("FAIL rand_pin_oeb cyc %0d got %h want %h", i, pin_oeb, ~m_dir); end
         checks++; if (irq !== m_irq) begin errors++; $display("FAIL rand_irq cyc %0d got %b want %b", i, irq, m_irq); end
         checks++; if (bus_rdata !== m_rdata) begin errors++; $display("FAIL rand_rdata cyc %0d got %h want %h", i, bus_rdata, m_rdata); end
      end
      bus_we = 1'b0;
      bus_re = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; bus_addr = 0; bus_wdata = 0; bus_we = 0; bus_re = 0; pin_in = 0;
      @(negedge clk);
      test_reset();
      test_output_path();
      test_edge_irq();
      test_disabled_edge();
      test_collision();
      test_rw_and_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/as2650_gpio_port.md
# as2650_gpio_port

Byte-wide general-purpose I/O port between the AS2650 core's internal I/O bus and the chip pad signals (`io_in`/`io_out`/`io_oeb`). It holds the output and direction registers, synchronises pad inputs, detects rising edges, and raises a level interrupt to the core. The core reaches it through a simple strobe-based register interface with fixed read latency.

## Interface
Parameters:
- `WIDTH`, 8, number of pins; 1..8, register bits above WIDTH read 0.
- `SYNC_STAGES`, 2, input synchroniser depth; minimum 2.

Ports:
- `wb_clk_i`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bus_addr`  in  2  register select: 0 DATA, 1 DIR, 2 IE, 3 IFLAG.
- `bus_wdata`  in  8  write data.
- `bus_we`  in  1  single-cycle write strobe.
- `bus_re`  in  1  single-cycle read strobe.
- `bus_rdata`  out  8  read data, registered.
- `pin_in`  in  WIDTH  raw pad inputs (asynchronous).
- `pin_out`  out  WIDTH  pad output values.
- `pin_oeb`  out  WIDTH  pad output enables, active-low.
- `irq`  out  1  level interrupt to core.

## Operation
- DATA (0): write loads `out_reg`. Read returns the synchronised pin value (last stage of the synchroniser), including pins driven as outputs.
- DIR (1): bit=1 makes the pin an output; `pin_oeb = ~dir_reg`. `pin_out = out_reg` regardless of DIR.
- IE (2): per-pin rising-edge interrupt enable, read/write.
- IFLAG (3): read returns flags; write-1-to-clear, write-0 no effect.
- Synchroniser: `SYNC_STAGES` flops per pin, then a `prev` flop; `edge[i] = sync[i] & ~prev[i]`.
- Flag set: `edge[i] & ie_reg[i]` sets `iflag[i]` on that clock edge. Edges with IE=0 are discarded and not remembered.
- Set/clear collision: a set and a W1C on the same bit in the same cycle leave the flag set.
- `irq` is a register loaded each cycle with `|iflag` of the current cycle.
- `bus_we` and `bus_re` asserted together: both are performed. Read data shows the pre-write register value.
- Reset values: `out_reg`=0, `dir_reg`=0, `ie_reg`=0, `iflag`=0, synchroniser and `prev`=0, `bus_rdata`=0, `irq`=0. Therefore `pin_out`=0 and `pin_oeb`=all 1s during and after reset.
- Reset mid-operation: asynchronous assertion clears all state immediately. Outputs take their reset values without waiting for a clock.
- After reset release, a pin already high produces one edge pulse. It is discarded because IE=0.

## Timing
- Write latency: `pin_out`/`pin_oeb` change on the clock edge that samples `bus_we`, visible in the following cycle.
- Read latency: `bus_rdata` is valid one cycle after `bus_re`. It holds until the next `bus_re`; it does not return to 0.
- Pin-to-DATA: a pin change sampled at edge k appears in DATA reads from edge k+SYNC_STAGES−1 onward.
- Pin-to-flag: for a rising pin sampled at edge k, `iflag` sets at edge k+SYNC_STAGES and `irq` asserts at edge k+SYNC_STAGES+1. With SYNC_STAGES=2 this is 3 cycles after the sampling edge.
- Clear-to-irq: a W1C clearing the last flag at edge m drops `irq` at edge m+1.
- No back-pressure: every strobe completes in one cycle, and strobes may be issued every cycle.

## Test plan
- Reset: hold `rst_n`=0 with random `pin_in` -> `pin_out`=0x00, `pin_oeb`=0xFF, `irq`=0, `bus_rdata`=0x00. Release reset; read IFLAG -> 0x00.
- Output path: write DIR=0x0F, then DATA=0xA5 -> next cycle `pin_oeb`=0xF0, `pin_out`=0xA5. With `pin_in`=0x3C, a DATA read after sync returns 0x3C one cycle after `bus_re`.
- Edge interrupt: write IE=0x01, raise `pin_in[0]` at edge k -> `iflag`=0x01 at k+2, `irq`=1 at k+3. Write IFLAG=0x01 -> `irq`=0 one cycle later.
- Disabled edge: IE=0x00, pulse `pin_in[1]` high, then write IE=0x02 -> IFLAG stays 0x00 and `irq` stays 0.
- Collision: IE=0xFF, schedule a pin-2 rising edge at the same edge as a W1C write of 0x04 to IFLAG -> IFLAG reads 0x04 and `irq` remains 1.
- Simultaneous read/write plus async reset: assert `bus_we`/`bus_re` on DIR with `bus_wdata`=0x55 while DIR=0x0F -> `bus_rdata`=0x0F and DIR reads 0x55 afterwards. Pull `rst_n` low mid-cycle -> `pin_oeb`=0xFF before the next clock edge.
